// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb_pkg
// Brief    : Shared types, default sizes and round-robin pick helper.
// Revision : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

   localparam int c_def_data_wd = 16;
   localparam int c_def_num_req = 4;
   localparam int c_max_req     = 16;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } rsp_state_t;

   // First set bit of valid at or above ptr, wrapping at n; one-hot or zero.
   function automatic logic [c_max_req-1:0] rr_pick(
      input logic [c_max_req-1:0] valid,
      input logic [3:0]           ptr,
      input int                   n
   );
      logic [c_max_req-1:0] grant;
      logic                 found;
      int                   idx;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < c_max_req; i++) begin
         idx = (int'(ptr) + i) % n;
         if (!found && (i < n) && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arb_adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Brief    : Unsigned adder keeping the carry as the result MSB.
// Revision : 1.0 - initial release
// ============================================================================
module adder #(
   parameter int DATA_WD = 16
) (
   input  logic [DATA_WD-1:0] i_a,
   input  logic [DATA_WD-1:0] i_b,
   output logic [DATA_WD:0]   o_sum
);

   assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule
`default_nettype wire

// File: rtl/adder_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin grant with rotating priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = c_def_num_req,
   parameter int ID_WD   = $clog2(NUM_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic               i_en,
   input  logic               i_accept,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_WD-1:0]   o_grant_id
);

   logic [ID_WD-1:0]     r_ptr;
   logic [c_max_req-1:0] w_pick;
   logic [ID_WD-1:0]     w_id;

   always_comb begin
      w_pick = rr_pick(c_max_req'(i_valid), 4'(r_ptr), NUM_REQ);
   end

   // Bits above NUM_REQ are always zero, so scanning the full width is safe.
   always_comb begin
      w_id = '0;
      for (int k = 0; k < c_max_req; k++) begin
         if (w_pick[k]) begin
            w_id = ID_WD'(k);
         end
      end
   end

   assign o_grant    = i_en ? w_pick[NUM_REQ-1:0] : '0;
   assign o_grant_id = w_id;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_accept) begin
         r_ptr <= (w_id == ID_WD'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/adder_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb
// Brief    : Shares one adder among NUM_REQ requesters; one-entry tagged result.
// Revision : 1.0 - initial release
// ============================================================================
module adder_arb
   import adder_arb_pkg::*;
#(
   parameter  int DATA_WD = c_def_data_wd,
   parameter  int NUM_REQ = c_def_num_req,
   localparam int ID_WD   = $clog2(NUM_REQ)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   input  logic [NUM_REQ*DATA_WD-1:0] i_req_a,
   input  logic [NUM_REQ*DATA_WD-1:0] i_req_b,
   output logic [NUM_REQ-1:0]         o_req_ready,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [DATA_WD:0]           o_rsp_sum,
   output logic [ID_WD-1:0]           o_rsp_id
);

   rsp_state_t          r_state;
   rsp_state_t          w_state_nxt;
   logic                w_can_accept;
   logic                w_accept;
   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_WD-1:0]    w_grant_id;
   logic [DATA_WD-1:0]  w_op_a;
   logic [DATA_WD-1:0]  w_op_b;
   logic [DATA_WD:0]    w_sum;

   assign w_can_accept = (r_state == EMPTY) | i_rsp_ready;
   assign w_accept     = |(i_req_valid & w_grant);
   assign o_req_ready  = w_grant;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_WD   (ID_WD)
   ) u_rr_arbiter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_req_valid),
      .i_en       (w_can_accept),
      .i_accept   (w_accept),
      .o_grant    (w_grant),
      .o_grant_id (w_grant_id)
   );

   // AND-OR mux: grant is one-hot or zero.
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_op_a = w_op_a | (i_req_a[k*DATA_WD +: DATA_WD] & {DATA_WD{w_grant[k]}});
         w_op_b = w_op_b | (i_req_b[k*DATA_WD +: DATA_WD] & {DATA_WD{w_grant[k]}});
      end
   end

   adder #(
      .DATA_WD (DATA_WD)
   ) u_adder (
      .i_a   (w_op_a),
      .i_b   (w_op_b),
      .o_sum (w_sum)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY:   if (w_accept) w_state_nxt = FULL;
         FULL:    if (i_rsp_ready && !w_accept) w_state_nxt = EMPTY;
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      o_rsp_valid = (r_state == FULL);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rsp_sum <= '0;
         o_rsp_id  <= '0;
      end else if (w_accept) begin
         o_rsp_sum <= w_sum;
         o_rsp_id  <= w_grant_id;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adder_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arb
// Brief    : Vector table plus scoreboard bench for adder_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arb;

   localparam int DW = 16;
   localparam int NR = 4;

   typedef struct {
      logic [NR-1:0]    valid;
      logic [NR*DW-1:0] a;
      logic [NR*DW-1:0] b;
      logic             rr;
      logic [NR-1:0]    exp_rdy;
   } vec_t;

   typedef struct {
      logic [DW:0] sum;
      logic [1:0]  id;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_a;
   logic [NR*DW-1:0] req_b;
   logic [NR-1:0]    req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [DW:0]      rsp_sum;
   logic [1:0]       rsp_id;

   int   errors = 0;
   int   checks = 0;
   rsp_t sb[$];
   vec_t tbl[$];

   localparam logic [NR*DW-1:0] c_all_a = {16'h4004, 16'h3003, 16'h2002, 16'h1001};
   localparam logic [NR*DW-1:0] c_all_b = {16'h0400, 16'h0300, 16'h0200, 16'h0100};

   always #5 clk = ~clk;

   adder_arb #(
      .DATA_WD (DW),
      .NUM_REQ (NR)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_sum   (rsp_sum),
      .o_rsp_id    (rsp_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR*DW-1:0] a,
                               input logic [NR*DW-1:0] b, input logic rr,
                               input logic [NR-1:0] e);
      vec_t t;
      t.valid = v; t.a = a; t.b = b; t.rr = rr; t.exp_rdy = e;
      return t;
   endfunction

   // Drive one cycle, check grant and response against the scoreboard, then clock.
   task automatic step(input vec_t t, input int n);
      rsp_t r;
      req_valid = t.valid;
      req_a     = t.a;
      req_b     = t.b;
      rsp_ready = t.rr;
      #1;
      chk($sformatf("ready[%0d]", n), 32'(req_ready), 32'(t.exp_rdy));
      chk($sformatf("rsp_valid[%0d]", n), 32'(rsp_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk($sformatf("rsp_sum[%0d]", n), 32'(rsp_sum), 32'(sb[0].sum));
         chk($sformatf("rsp_id[%0d]", n), 32'(rsp_id), 32'(sb[0].id));
         if (t.rr) void'(sb.pop_front());
      end
      for (int k = 0; k < NR; k++) begin
         if (t.exp_rdy[k] && t.valid[k]) begin
            r.sum = {1'b0, t.a[k*DW +: DW]} + {1'b0, t.b[k*DW +: DW]};
            r.id  = 2'(k);
            sb.push_back(r);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #1;
      chk("reset_valid", 32'(rsp_valid), 32'd0);
      chk("reset_sum", 32'(rsp_sum), 32'd0);
      chk("reset_id", 32'(rsp_id), 32'd0);
      chk("reset_ready", 32'(req_ready), 32'd0);

      // single request, max operands, then prime pointer to 0
      tbl.push_back(mk(4'b0100, 64'h0000_1234_0000_0000, 64'h0000_0001_0000_0000, 1'b1, 4'b0100));
      tbl.push_back(mk(4'b0000, '0, '0, 1'b1, 4'b0000));
      tbl.push_back(mk(4'b0001, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 1'b1, 4'b0001));
      tbl.push_back(mk(4'b0000, '0, '0, 1'b1, 4'b0000));
      tbl.push_back(mk(4'b1000, 64'h7FFF_0000_0000_0000, 64'h8001_0000_0000_0000, 1'b1, 4'b1000));
      // round robin 0,1,2,3,0,1
      tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b1, 4'b0001));
      tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b1, 4'b0010));
      tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b1, 4'b0100));
      tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b1, 4'b1000));
      tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b1, 4'b0001));
      tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b1, 4'b0010));
      // backpressure then back-to-back accept
      for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b0, 4'b0000));
      tbl.push_back(mk(4'b1111, c_all_a, c_all_b, 1'b1, 4'b0100));
      tbl.push_back(mk(4'b0000, '0, '0, 1'b1, 4'b0000));
      // pointer skip: ptr=1 with only 0 and 3 valid
      tbl.push_back(mk(4'b0001, c_all_a, c_all_b, 1'b1, 4'b0001));
      tbl.push_back(mk(4'b1001, c_all_a, c_all_b, 1'b1, 4'b1000));
      tbl.push_back(mk(4'b1001, c_all_a, c_all_b, 1'b1, 4'b0001));
      tbl.push_back(mk(4'b0000, '0, '0, 1'b1, 4'b0000));
      // requester 2 drops valid before grant; pointer must stay at 2
      tbl.push_back(mk(4'b0010, c_all_a, c_all_b, 1'b0, 4'b0010));
      tbl.push_back(mk(4'b0100, c_all_a, c_all_b, 1'b0, 4'b0000));
      tbl.push_back(mk(4'b0000, '0, '0, 1'b1, 4'b0000));
      tbl.push_back(mk(4'b1001, c_all_a, c_all_b, 1'b1, 4'b1000));
      tbl.push_back(mk(4'b0000, '0, '0, 1'b1, 4'b0000));

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // reset while holding a result from requester 3
      step(mk(4'b1000, c_all_a, c_all_b, 1'b0, 4'b1000), 100);
      req_valid = '0;
      #1;
      chk("held_valid", 32'(rsp_valid), 32'd1);
      chk("held_id", 32'(rsp_id), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst_sum", 32'(rsp_sum), 32'd0);
      chk("async_rst_id", 32'(rsp_id), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(mk(4'b1010, c_all_a, c_all_b, 1'b1, 4'b0010), 101);
      step(mk(4'b0000, '0, '0, 1'b1, 4'b0000), 102);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
